// File: rtl/text_console_writer.sv
// Character-stream writer for text-mode video memory: packs 6-bit glyphs three per
// 18-bit word, tracks a cursor, handles newline and clear; TEXT_SCROLL_EN adds scrolling.
module text_console_writer #(
  parameter int BASE_ADDR     = 256,
  parameter int WORDS_PER_ROW = 27,
  parameter int ROWS          = 60,
  parameter int COLS          = 80
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        char_valid,
  input  logic [5:0]  char_code,
  input  logic        char_nl,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [17:0] mem_din,
  input  logic [17:0] mem_dout,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [10:0] BASE         = 11'(BASE_ADDR);
  localparam logic [10:0] WPR          = 11'(WORDS_PER_ROW);
  localparam logic [10:0] SCREEN_LAST  = 11'(ROWS * WORDS_PER_ROW - 1);
  localparam logic [6:0]  COL_LAST     = 7'(COLS - 1);
  localparam logic [5:0]  ROW_LAST     = 6'(ROWS - 1);
`ifdef TEXT_SCROLL_EN
  localparam logic [10:0] SCROLL_WORDS = 11'((ROWS - 1) * WORDS_PER_ROW);
  localparam logic [10:0] SCROLL_LAST  = 11'((ROWS - 1) * WORDS_PER_ROW - 1);
  localparam logic [10:0] WPR_LAST     = 11'(WORDS_PER_ROW - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    NL,
    CLEAR
`ifdef TEXT_SCROLL_EN
    ,
    SCR_RD,
    SCR_WR,
    SCR_CLR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  code_q, code_d;
  logic [10:0] cnt_q, cnt_d;

  logic [10:0] word_addr;
  logic [6:0]  col_word;
  logic [6:0]  col_slot;
  logic        line_feed;

  assign col_word   = col_q / 7'd3;
  assign col_slot   = col_q % 7'd3;
  assign word_addr  = BASE + 11'(row_q) * WPR + 11'(col_word);

  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q != IDLE);

  // NOTE: every state element uses <= so all registers update together from
  // values sampled at the same edge; blocking here would create order races.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    char_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = BASE;
    mem_din    = '0;
    line_feed  = 1'b0;

    unique case (state_q)
      IDLE: begin
        char_ready = !clear_req;
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (char_valid) begin
          cnt_d = '0;
          if (char_nl) begin
            state_d = NL;
          end else begin
            state_d = RD;
            code_d  = char_code;
          end
        end
      end

      // Two read cycles give the three-cycle character slot; dout is valid by WR.
      RD: begin
        mem_addr = word_addr;
        if (cnt_q == 11'd0) cnt_d = 11'd1;
        else                state_d = WR;
      end

      WR: begin
        mem_we   = 1'b1;
        mem_addr = word_addr;
        case (col_slot[1:0])
          2'd0:    mem_din = {code_q, mem_dout[11:0]};
          2'd1:    mem_din = {mem_dout[17:12], code_q, mem_dout[5:0]};
          default: mem_din = {mem_dout[17:6], code_q};
        endcase
        if (col_q == COL_LAST) begin
          line_feed = 1'b1;
        end else begin
          col_d   = col_q + 7'd1;
          state_d = IDLE;
        end
      end

      NL: line_feed = 1'b1;

      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = BASE + cnt_q;
        if (cnt_q == SCREEN_LAST) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

`ifdef TEXT_SCROLL_EN
      SCR_RD: begin
        mem_addr = BASE + WPR + cnt_q;
        state_d  = SCR_WR;
      end

      SCR_WR: begin
        mem_we   = 1'b1;
        mem_addr = BASE + cnt_q;
        mem_din  = mem_dout;
        if (cnt_q == SCROLL_LAST) begin
          state_d = SCR_CLR;
          cnt_d   = '0;
        end else begin
          state_d = SCR_RD;
          cnt_d   = cnt_q + 11'd1;
        end
      end

      SCR_CLR: begin
        mem_we   = 1'b1;
        mem_addr = BASE + SCROLL_WORDS + cnt_q;
        if (cnt_q == WPR_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 11'd1;
      end
`endif

      default: state_d = IDLE;
    endcase

    if (line_feed) begin
      col_d   = '0;
      state_d = IDLE;
      if (row_q == ROW_LAST) begin
`ifdef TEXT_SCROLL_EN
        // The cursor stays on the last row while the screen moves up beneath it.
        state_d = SCR_RD;
        cnt_d   = '0;
`else
        row_d = '0;
`endif
      end else begin
        row_d = row_q + 6'd1;
      end
    end
  end

endmodule
